div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_pkg.sv | 29 ++
 rtl/div_seq_step.sv | 23 ++
 rtl/div_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared constants, state encoding and helpers for the sequential divider.
package div_seq_pkg;

    localparam logic RstEnable         = 1'b1;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam int   DoubleRegBus      = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Magnitude of a 32-bit operand; 0x80000000 maps onto itself.
    function automatic logic [31:0] mag32(input logic [31:0] v,
                                          input logic        sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v,
                                           input logic        n);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring trial-subtraction step on the {remainder, quotient} register.
module div_step
    import div_seq_pkg::*;
(
    input  logic [64:0] work_i,
    input  logic [31:0] divisor_i,
    output logic [64:0] work_o
);

    logic [65:0] shifted;
    logic [33:0] trial;

    always_comb begin
        shifted = {work_i, 1'b0};
        trial   = shifted[65:32] - {2'b00, divisor_i};
        work_o  = shifted[64:0];
        // No borrow means the divisor fits: keep the difference, emit a 1.
        if (!trial[33]) begin
            work_o = {trial[32:0], shifted[31:1], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Iterative 32-bit signed/unsigned divider, one quotient bit per cycle.
module div_seq
    import div_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [31:0]             opdata1_i,
    input  logic [31:0]             opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o,
    output logic                    busy_o
);

    div_state_e              state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [64:0]             work_q, work_d;
    logic [31:0]             dvsr_q, dvsr_d;
    logic                    qneg_q, qneg_d;
    logic                    rneg_q, rneg_d;
    logic [DoubleRegBus-1:0] result_q, result_d;
    logic [64:0]             step_out;

    div_step u_step (
        .work_i    (work_q),
        .divisor_i (dvsr_q),
        .work_o    (step_out)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvsr_d   = dvsr_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = '0;
        unique case (state_q)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    dvsr_d = mag32(opdata2_i, signed_div_i);
                    work_d = {33'd0, mag32(opdata1_i, signed_div_i)};
                    qneg_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                    rneg_d = signed_div_i & opdata1_i[31];
                    cnt_d  = '0;
                    state_d = (opdata2_i == 32'd0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                state_d = annul_i ? DivFree : DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                    cnt_d   = '0;
                    work_d  = '0;
                end else begin
                    work_d = step_out;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = DivEnd;
                        result_d = {neg_if(step_out[63:32], rneg_q),
                                    neg_if(step_out[31:0], qneg_q)};
                    end
                end
            end
            DivEnd: begin
                if (annul_i || start_i == DivStop) begin
                    state_d = DivFree;
                end else begin
                    result_d = result_q;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            work_q   <= '0;
            dvsr_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvsr_q   <= dvsr_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == DivEnd) ? DivResultReady
                                          : DivResultNotReady;
    assign busy_o   = (state_q == DivOn) || (state_q == DivByZero);

endmodule
